// File: rtl/pe_ctrl_pkg.sv
// Shared encodings for the PE issue controller: opcode classes, function codes,
// ALU selects, writeback/memory-size encodings and the controller state type.
package pe_ctrl_pkg;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ST   = 3'b010;
    localparam logic [2:0] OP_TPFX = 3'b011;
    localparam logic [2:0] OP_IPFX = 3'b100;
    localparam logic [2:0] OP_FRAG = 3'b101;

    localparam logic [3:0] FUN_RECV   = 4'd0;
    localparam logic [3:0] FUN_LB     = 4'd1;
    localparam logic [3:0] FUN_LH     = 4'd2;
    localparam logic [3:0] FUN_LW     = 4'd3;
    localparam logic [3:0] FUN_LBU    = 4'd4;
    localparam logic [3:0] FUN_LHU    = 4'd5;
    localparam logic [3:0] FUN_INVOKE = 4'd6;

    localparam logic [3:0] FUN_SEND = 4'd0;
    localparam logic [3:0] FUN_SB   = 4'd1;
    localparam logic [3:0] FUN_SH   = 4'd2;
    localparam logic [3:0] FUN_SW   = 4'd3;
    localparam logic [3:0] FUN_TERM = 4'd4;

    localparam logic [3:0] FUN_FSTART = 4'd0;
    localparam logic [3:0] FUN_FEND   = 4'd1;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b1111;

    localparam logic [1:0] O_ALU  = 2'd0;
    localparam logic [1:0] O_RECV = 2'd1;
    localparam logic [1:0] O_MEM  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_DECODE,
        ST_RECV_WAIT,
        ST_SEND_WAIT,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    // Returns {legal, alu_sel} for an ALU-class function code.
    function automatic logic [4:0] alu_decode(input logic [3:0] fun);
        case (fun)
            4'd0:    return {1'b1, ALU_OR};
            4'd1:    return {1'b1, ALU_AND};
            4'd2:    return {1'b1, ALU_XOR};
            4'd3:    return {1'b1, ALU_ADD};
            4'd4:    return {1'b1, ALU_SUB};
            4'd5:    return {1'b1, ALU_SLT};
            4'd6:    return {1'b1, ALU_SLTU};
            4'd7:    return {1'b1, ALU_SLL};
            4'd8:    return {1'b1, ALU_SRL};
            4'd9:    return {1'b1, ALU_SRA};
            default: return 5'b0;
        endcase
    endfunction

endpackage

// File: rtl/pe_imm_acc.sv
// Immediate prefix accumulator: shifts IMM_W bits in per I prefix and counts
// consecutive prefixes so the controller can flag an overlong chain.
module pe_imm_acc #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 8,
    parameter int MAX_PFX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              clr,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] imm_next,
    output logic              pending,
    output logic              full
);

    localparam int CNT_W = $clog2(MAX_PFX + 1);

    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    // Oldest bits fall off the top once the chain exceeds the accumulator.
    assign imm_next = (acc_q << IMM_W) | DATA_W'(imm);
    assign pending  = (cnt_q != '0);
    assign full     = (cnt_q == CNT_W'(MAX_PFX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            acc_q <= imm_next;
            if (!full)
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pe_issue_ctrl.sv
// PE issue controller: accepts decoded instructions and sequences ALU, channel
// and memory operations. Optional predication is enabled by defining PE_PRED_EN.
//
// state        | meaning
// ST_DECODE    | ready for the next instruction
// ST_RECV_WAIT | waiting for data on the latched target channel
// ST_SEND_WAIT | pushing to the latched target channel until it is taken
// ST_MEM_WAIT  | memory request outstanding until mem_ack
// ST_HALT      | terminated, waiting for start_i
module pe_issue_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 8,
    parameter int NUM_CH  = 4,
    parameter int MAX_PFX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [2:0]        ins_op,
    input  logic [3:0]        ins_fun,
    input  logic [IMM_W-1:0]  ins_imm,
    input  logic              pred_i,
    input  logic              start_i,
    output logic [3:0]        alu_sel,
    output logic              a_sel,
    output logic              b_sel,
    output logic [1:0]        o_sel,
    output logic [DATA_W-1:0] imm_o,
    output logic              ex_valid,
    input  logic [NUM_CH-1:0] recv_valid,
    output logic [NUM_CH-1:0] recv_ready,
    output logic [NUM_CH-1:0] send_valid,
    input  logic [NUM_CH-1:0] send_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic              mem_uns,
    input  logic              mem_ack,
    output logic              invoke_o,
    output logic              frag_start_o,
    output logic              frag_end_o,
    output logic              ill_o,
    output logic              done_o
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t state_q, state_d;

    logic              accept, is_tpfx, is_ipfx, non_pfx, t_bad, pred_ok, exec;
    logic              dec_legal, dec_alu, dec_recv, dec_send, dec_load, dec_store;
    logic              dec_halt, dec_invoke, dec_fstart, dec_fend, dec_uns;
    logic [3:0]        dec_alu_code;
    logic [1:0]        dec_size;
    logic [DATA_W-1:0] imm_next;
    logic              pfx_pending, pfx_full;

    logic [CH_W-1:0]   tgt_q, ch_q;
    logic [3:0]        alu_q;
    logic              b_q, we_q, uns_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] imm_q;
    logic              ex_q, invoke_q, fstart_q, fend_q, ill_q;
    logic [NUM_CH-1:0] ch_onehot;
    logic              recv_hit, load_hit;

`ifdef PE_PRED_EN
    assign pred_ok = pred_i;
`else
    logic unused_pred;
    assign unused_pred = pred_i;
    assign pred_ok     = 1'b1;
`endif

    assign ins_ready = (state_q == ST_DECODE);
    assign accept    = ins_valid & ins_ready;
    assign is_tpfx   = (ins_op == OP_TPFX);
    assign is_ipfx   = (ins_op == OP_IPFX);
    assign non_pfx   = !is_tpfx && !is_ipfx;
    assign t_bad     = (ins_imm >= IMM_W'(NUM_CH));
    assign exec      = accept & non_pfx & pred_ok & dec_legal;

    pe_imm_acc #(.DATA_W(DATA_W), .IMM_W(IMM_W), .MAX_PFX(MAX_PFX)) u_imm_acc (
        .clk      (clk),
        .rst      (rst),
        .push     (accept & is_ipfx),
        .clr      (accept & non_pfx),
        .imm      (ins_imm),
        .imm_next (imm_next),
        .pending  (pfx_pending),
        .full     (pfx_full)
    );

    always_comb begin
        dec_legal    = 1'b0;
        dec_alu      = 1'b0;
        dec_alu_code = '0;
        dec_recv     = 1'b0;
        dec_send     = 1'b0;
        dec_load     = 1'b0;
        dec_store    = 1'b0;
        dec_halt     = 1'b0;
        dec_invoke   = 1'b0;
        dec_fstart   = 1'b0;
        dec_fend     = 1'b0;
        dec_size     = SZ_BYTE;
        dec_uns      = 1'b0;
        case (ins_op)
            OP_ALU: begin
                {dec_alu, dec_alu_code} = alu_decode(ins_fun);
                dec_legal = dec_alu;
            end
            OP_LD: begin
                case (ins_fun)
                    FUN_RECV:   dec_recv = 1'b1;
                    FUN_LB:     dec_load = 1'b1;
                    FUN_LH:     begin dec_load = 1'b1; dec_size = SZ_HALF; end
                    FUN_LW:     begin dec_load = 1'b1; dec_size = SZ_WORD; end
                    FUN_LBU:    begin dec_load = 1'b1; dec_uns = 1'b1; end
                    FUN_LHU:    begin dec_load = 1'b1; dec_uns = 1'b1; dec_size = SZ_HALF; end
                    FUN_INVOKE: dec_invoke = 1'b1;
                    default:    ;
                endcase
                dec_legal = dec_recv | dec_load | dec_invoke;
            end
            OP_ST: begin
                case (ins_fun)
                    FUN_SEND: dec_send = 1'b1;
                    FUN_SB:   dec_store = 1'b1;
                    FUN_SH:   begin dec_store = 1'b1; dec_size = SZ_HALF; end
                    FUN_SW:   begin dec_store = 1'b1; dec_size = SZ_WORD; end
                    FUN_TERM: dec_halt = 1'b1;
                    default:  ;
                endcase
                dec_legal = dec_send | dec_store | dec_halt;
            end
            OP_FRAG: begin
                dec_fstart = (ins_fun == FUN_FSTART);
                dec_fend   = (ins_fun == FUN_FEND);
                dec_legal  = dec_fstart | dec_fend;
            end
            OP_TPFX, OP_IPFX: dec_legal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_DECODE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DECODE: begin
                if (exec) begin
                    if (dec_recv)
                        state_d = ST_RECV_WAIT;
                    else if (dec_send)
                        state_d = ST_SEND_WAIT;
                    else if (dec_load || dec_store)
                        state_d = ST_MEM_WAIT;
                    else if (dec_halt)
                        state_d = ST_HALT;
                end
            end
            ST_RECV_WAIT: if (recv_valid[ch_q]) state_d = ST_DECODE;
            ST_SEND_WAIT: if (send_ready[ch_q]) state_d = ST_DECODE;
            ST_MEM_WAIT:  if (mem_ack)          state_d = ST_DECODE;
            ST_HALT:      if (start_i)          state_d = ST_DECODE;
            default:      state_d = ST_DECODE;
        endcase
    end

    // Selects and pulses for the accepted instruction land one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q    <= '0;
            ch_q     <= '0;
            alu_q    <= '0;
            b_q      <= 1'b0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            imm_q    <= '0;
            ex_q     <= 1'b0;
            invoke_q <= 1'b0;
            fstart_q <= 1'b0;
            fend_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            ex_q     <= 1'b0;
            invoke_q <= 1'b0;
            fstart_q <= 1'b0;
            fend_q   <= 1'b0;
            ill_q    <= 1'b0;
            if (accept) begin
                if (is_tpfx) begin
                    if (t_bad)
                        ill_q <= 1'b1;
                    else
                        tgt_q <= ins_imm[CH_W-1:0];
                end else if (is_ipfx) begin
                    ill_q <= pfx_full;
                end else begin
                    tgt_q <= '0;
                    if (pred_ok) begin
                        imm_q    <= imm_next;
                        ill_q    <= !dec_legal;
                        invoke_q <= dec_invoke;
                        fstart_q <= dec_fstart;
                        fend_q   <= dec_fend;
                        if (dec_alu) begin
                            alu_q <= dec_alu_code;
                            b_q   <= pfx_pending;
                            ex_q  <= 1'b1;
                        end
                        if (dec_recv || dec_send)
                            ch_q <= tgt_q;
                        if (dec_load || dec_store) begin
                            we_q   <= dec_store;
                            size_q <= dec_size;
                            uns_q  <= dec_uns;
                        end
                    end
                end
            end
        end
    end

    assign ch_onehot = NUM_CH'(1) << ch_q;
    assign recv_hit  = (state_q == ST_RECV_WAIT) && recv_valid[ch_q];
    assign load_hit  = (state_q == ST_MEM_WAIT) && mem_ack && !we_q;

    always_comb begin
        recv_ready = '0;
        send_valid = '0;
        o_sel      = O_ALU;
        if (recv_hit) begin
            recv_ready = ch_onehot;
            o_sel      = O_RECV;
        end else if (load_hit) begin
            o_sel = O_MEM;
        end
        if (state_q == ST_SEND_WAIT)
            send_valid = ch_onehot;
    end

    assign mem_req      = (state_q == ST_MEM_WAIT);
    assign mem_we       = mem_req & we_q;
    assign mem_size     = mem_req ? size_q : SZ_BYTE;
    assign mem_uns      = mem_req & uns_q;
    assign a_sel        = recv_hit | load_hit;
    assign ex_valid     = ex_q | recv_hit | load_hit;
    assign alu_sel      = alu_q;
    assign b_sel        = b_q;
    assign imm_o        = imm_q;
    assign invoke_o     = invoke_q;
    assign frag_start_o = fstart_q;
    assign frag_end_o   = fend_q;
    assign ill_o        = ill_q;
    assign done_o       = (state_q == ST_HALT);

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Directed bench for pe_issue_ctrl with an ex_valid scoreboard; covers the
// PE_PRED_EN build as well as the default one.
module tb_pe_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid, ins_ready;
    logic [2:0]  ins_op;
    logic [3:0]  ins_fun;
    logic [7:0]  ins_imm;
    logic        pred_i, start_i;
    logic [3:0]  alu_sel;
    logic        a_sel, b_sel;
    logic [1:0]  o_sel;
    logic [31:0] imm_o;
    logic        ex_valid;
    logic [3:0]  recv_valid, recv_ready, send_valid, send_ready;
    logic        mem_req, mem_we, mem_uns, mem_ack;
    logic [1:0]  mem_size;
    logic        invoke_o, frag_start_o, frag_end_o, ill_o, done_o;

    int errors = 0;
    int checks = 0;
    int recv_pulses = 0;
    int mem_cycles = 0;

    typedef struct {
        logic        chk_alu;
        logic [3:0]  alu;
        logic        b;
        logic [1:0]  o;
        logic        a;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [3:0] alu_tab [10] = '{4'b1001, 4'b1000, 4'b1010, 4'b0000, 4'b0001,
                                 4'b1111, 4'b1101, 4'b0100, 4'b0101, 4'b0111};

    always #5 clk = ~clk;

    pe_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_op(ins_op), .ins_fun(ins_fun), .ins_imm(ins_imm),
        .pred_i(pred_i), .start_i(start_i),
        .alu_sel(alu_sel), .a_sel(a_sel), .b_sel(b_sel), .o_sel(o_sel),
        .imm_o(imm_o), .ex_valid(ex_valid),
        .recv_valid(recv_valid), .recv_ready(recv_ready),
        .send_valid(send_valid), .send_ready(send_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_uns(mem_uns), .mem_ack(mem_ack),
        .invoke_o(invoke_o), .frag_start_o(frag_start_o),
        .frag_end_o(frag_end_o), .ill_o(ill_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic send_ins(input logic [2:0] op, input logic [3:0] fun, input logic [7:0] imm);
        ins_op    = op;
        ins_fun   = fun;
        ins_imm   = imm;
        ins_valid = 1'b1;
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
    endtask

    task automatic push_alu(input logic [3:0] alu, input logic b, input logic [31:0] imm);
        exp_t e;
        e = '{chk_alu: 1'b1, alu: alu, b: b, o: 2'd0, a: 1'b0, imm: imm};
        sb.push_back(e);
    endtask

    task automatic push_data(input logic [1:0] o);
        exp_t e;
        e = '{chk_alu: 1'b0, alu: 4'd0, b: 1'b0, o: o, a: 1'b1, imm: 32'd0};
        sb.push_back(e);
    endtask

    // Scoreboard side: every ex_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (|recv_ready) recv_pulses++;
            if (mem_req)     mem_cycles++;
            if (ex_valid) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL ex_spurious: observed ex_valid=1 expected no pulse, o_sel=%0d", o_sel);
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("sb_o_sel", 32'(o_sel), 32'(mon_e.o));
                    chk("sb_a_sel", 32'(a_sel), 32'(mon_e.a));
                    if (mon_e.chk_alu) begin
                        chk("sb_alu_sel", 32'(alu_sel), 32'(mon_e.alu));
                        chk("sb_b_sel", 32'(b_sel), 32'(mon_e.b));
                        chk("sb_imm_o", imm_o, mon_e.imm);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ins_valid = 1'b0; ins_op = '0; ins_fun = '0; ins_imm = '0;
        pred_i = 1'b1; start_i = 1'b0; recv_valid = '0; send_ready = '0; mem_ack = 1'b0;
        step(); step();
        chk("rst_ins_ready", 32'(ins_ready), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_imm_o", imm_o, 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        rst = 1'b0;

        // single ADD, no prefix
        push_alu(4'b0000, 1'b0, 32'h5);
        send_ins(3'b000, 4'd3, 8'h05);
        smp();
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ins_ready", 32'(ins_ready), 32'd1);
        step(); smp();
        chk("add_ex_one_cycle", 32'(ex_valid), 32'd0);

        // all ALU functions back to back, then an unused ALU fun
        for (int f = 0; f < 10; f++) begin
            push_alu(alu_tab[f], 1'b0, 32'(f + 16));
            send_ins(3'b000, 4'(f), 8'(f + 16));
        end
        send_ins(3'b000, 4'd12, 8'h00);
        smp();
        chk("alu_bad_fun_ill", 32'(ill_o), 32'd1);

        // two I prefixes then ADD, then a plain ADD
        send_ins(3'b100, 4'd0, 8'h12);
        send_ins(3'b100, 4'd0, 8'h34);
        push_alu(4'b0000, 1'b1, 32'h00123456);
        send_ins(3'b000, 4'd3, 8'h56);
        push_alu(4'b0000, 1'b0, 32'h00000000);
        send_ins(3'b000, 4'd3, 8'h00);

        // T 2 then recv with target bit low for 3 cycles
        recv_valid = 4'b1011;
        send_ins(3'b011, 4'd0, 8'd2);
        send_ins(3'b001, 4'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("recv_wait_ready", 32'(ins_ready), 32'd0);
            chk("recv_wait_pop", 32'(recv_ready), 32'd0);
            step();
        end
        recv_valid = 4'b0100;
        push_data(2'd1);
        smp();
        chk("recv_pop", 32'(recv_ready), 32'b0100);
        step();
        recv_valid = '0;
        smp();
        chk("recv_back_ready", 32'(ins_ready), 32'd1);
        chk("recv_pop_once", 32'(recv_pulses), 32'd1);

        // lw with ack in the 4th cycle
        send_ins(3'b001, 4'd3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("lw_req", 32'(mem_req), 32'd1);
            chk("lw_size", 32'(mem_size), 32'd2);
            chk("lw_we", 32'(mem_we), 32'd0);
            step();
        end
        mem_ack = 1'b1;
        push_data(2'd2);
        smp();
        chk("lw_req_ack_cycle", 32'(mem_req), 32'd1);
        step();
        mem_ack = 1'b0;
        smp();
        chk("lw_req_dropped", 32'(mem_req), 32'd0);
        chk("lw_req_cycles", 32'(mem_cycles), 32'd4);

        // sh with immediate ack, no writeback pulse
        send_ins(3'b010, 4'd2, 8'd0);
        mem_ack = 1'b1;
        smp();
        chk("sh_we", 32'(mem_we), 32'd1);
        chk("sh_size", 32'(mem_size), 32'd1);
        step();
        mem_ack = 1'b0;
        smp();
        chk("sh_req_dropped", 32'(mem_req), 32'd0);

        // send on channel 1, other ready bits set meanwhile
        send_ins(3'b011, 4'd0, 8'd1);
        send_ins(3'b010, 4'd0, 8'd0);
        send_ready = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("send_valid_wait", 32'(send_valid), 32'b0010);
            step();
        end
        send_ready = 4'b0010;
        smp();
        chk("send_valid_take", 32'(send_valid), 32'b0010);
        step();
        send_ready = '0;
        smp();
        chk("send_done_valid", 32'(send_valid), 32'd0);
        chk("send_done_ready", 32'(ins_ready), 32'd1);

        // illegal T, illegal op clearing a prefix, invoke and fragment markers
        send_ins(3'b011, 4'd0, 8'd5);
        smp();
        chk("t_bad_ill", 32'(ill_o), 32'd1);
        send_ins(3'b100, 4'd0, 8'h77);
        smp();
        chk("ipfx_ok_ill", 32'(ill_o), 32'd0);
        send_ins(3'b110, 4'd0, 8'h00);
        smp();
        chk("op6_ill", 32'(ill_o), 32'd1);
        push_alu(4'b1001, 1'b0, 32'h00000001);
        send_ins(3'b000, 4'd0, 8'h01);
        send_ins(3'b001, 4'd6, 8'h00);
        smp();
        chk("invoke", 32'(invoke_o), 32'd1);
        send_ins(3'b101, 4'd0, 8'h00);
        smp();
        chk("frag_start", 32'(frag_start_o), 32'd1);
        chk("frag_start_only", 32'(frag_end_o), 32'd0);
        send_ins(3'b101, 4'd1, 8'h00);
        smp();
        chk("frag_end", 32'(frag_end_o), 32'd1);

        // five I prefixes: the fifth is flagged and drops the oldest byte
        for (int k = 0; k < 5; k++) begin
            send_ins(3'b100, 4'd0, 8'((k + 1) * 8'h11));
            smp();
            chk("pfx_chain_ill", 32'(ill_o), (k == 4) ? 32'd1 : 32'd0);
        end
        push_alu(4'b1010, 1'b1, 32'h3344559A);
        send_ins(3'b000, 4'd2, 8'h9A);

        // terminate, hold an instruction, then restart
        send_ins(3'b010, 4'd4, 8'h00);
        smp();
        chk("halt_done", 32'(done_o), 32'd1);
        chk("halt_not_ready", 32'(ins_ready), 32'd0);
        ins_op = 3'b000; ins_fun = 4'd3; ins_imm = 8'h01; ins_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            chk("halt_hold_done", 32'(done_o), 32'd1);
            chk("halt_hold_ready", 32'(ins_ready), 32'd0);
        end
        step();
        ins_valid = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        smp();
        chk("start_ready", 32'(ins_ready), 32'd1);
        chk("start_done", 32'(done_o), 32'd0);

        // predicate-false send
        pred_i = 1'b0;
        send_ins(3'b011, 4'd0, 8'd1);
        send_ins(3'b010, 4'd0, 8'd0);
        smp();
`ifdef PE_PRED_EN
        chk("pred_no_send", 32'(send_valid), 32'd0);
        chk("pred_ready", 32'(ins_ready), 32'd1);
`else
        chk("nopred_send", 32'(send_valid), 32'b0010);
        send_ready = 4'b0010;
        step();
        send_ready = '0;
        smp();
        chk("nopred_ready", 32'(ins_ready), 32'd1);
`endif
        pred_i = 1'b1;
        step();

        // reset while a send is outstanding
        send_ins(3'b011, 4'd0, 8'd0);
        send_ins(3'b010, 4'd0, 8'd0);
        send_ready = 4'b1110;
        smp();
        chk("pre_rst_send", 32'(send_valid), 32'b0001);
        #2 rst = 1'b1;
        #1;
        chk("rst_send_async", 32'(send_valid), 32'd0);
        chk("rst_ready_async", 32'(ins_ready), 32'd1);
        step();
        rst = 1'b0;
        send_ready = '0;
        smp();
        chk("post_rst_send", 32'(send_valid), 32'd0);

        step(); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
